// File: rtl/bin_frame_line_feeder.sv
// ---------------------------------------------------------------------------
// bin_frame_line_feeder
//
// Captures one binarized frame (1 bit/pixel) from the pixel pipeline, packs
// each line into an H_PIX-bit word held in an on-chip row memory, then serves
// the rows one at a time to the vision core with a start / data_update / stop
// handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pix_valid/bit/sof    pixel strobe, pixel value, first-pixel-of-frame flag
//   line_pixel           current row, first pixel of the line at the MSB
//   start                one-cycle pulse: line_pixel is ready for the core
//   data_update          one-cycle pulse from the core: row consumed
//   stop                 core abort / finish request
//   busy                 high while capturing or serving
//   frame_done           one-cycle pulse when serving ends (completion/stop)
//   sof_err              one-cycle pulse: pix_sof arrived mid-capture
//   drop_cnt             frames dropped while serving, saturating at 255
// ---------------------------------------------------------------------------
module bin_frame_line_feeder #(
    parameter int unsigned H_PIX     = 320,
    parameter int unsigned V_LINES   = 240,
    parameter int unsigned ROW_AW    = 8,
    parameter int unsigned START_DLY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_bit,
    input  logic             pix_sof,
    output logic [H_PIX-1:0] line_pixel,
    output logic             start,
    input  logic             data_update,
    input  logic             stop,
    output logic             busy,
    output logic             frame_done,
    output logic             sof_err,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned       COL_W    = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_PIX - 1);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(V_LINES - 1);
    localparam logic [2:0]        DLY_LAST = 3'(START_DLY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOAD,
        ST_WAIT_ST,
        ST_SERVE
    } state_t;

    state_t            state_q,      state_d;
    logic [COL_W-1:0]  col_q,        col_d;
    logic [ROW_AW-1:0] wr_row_q,     wr_row_d;
    logic [ROW_AW-1:0] rd_row_q,     rd_row_d;
    logic [H_PIX-1:0]  pack_q,       pack_d;
    logic              load_ph_q,    load_ph_d;
    logic [2:0]        dly_q,        dly_d;
    logic [H_PIX-1:0]  line_pixel_q, line_pixel_d;
    logic              start_q,      start_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_err_q,    sof_err_d;
    logic [7:0]        drop_cnt_q,   drop_cnt_d;

    logic [H_PIX-1:0]  mem [V_LINES];
    logic [H_PIX-1:0]  rd_data_q;
    logic [H_PIX-1:0]  pack_shift;
    logic              mem_we;
    logic              rd_en;
    logic              sof_v;

    assign pack_shift = {pack_q[H_PIX-2:0], pix_bit};
    assign sof_v      = pix_valid && pix_sof;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        wr_row_d     = wr_row_q;
        rd_row_d     = rd_row_q;
        pack_d       = pack_q;
        load_ph_d    = load_ph_q;
        dly_d        = dly_q;
        line_pixel_d = line_pixel_q;
        drop_cnt_d   = drop_cnt_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        mem_we       = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sof_v) begin
                    pack_d   = pack_shift;
                    col_d    = COL_W'(1);
                    wr_row_d = '0;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid) begin
                    pack_d = pack_shift;
                    if (pix_sof) begin
                        // Restart: this pixel becomes column 0 of row 0.
                        sof_err_d = 1'b1;
                        col_d     = COL_W'(1);
                        wr_row_d  = '0;
                    end else if (col_q == COL_LAST) begin
                        mem_we = 1'b1;
                        col_d  = '0;
                        if (wr_row_q == ROW_LAST) begin
                            wr_row_d  = '0;
                            rd_row_d  = '0;
                            load_ph_d = 1'b0;
                            state_d   = ST_LOAD;
                        end else begin
                            wr_row_d = wr_row_q + ROW_AW'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                // Phase 0 registers the memory word, phase 1 moves it to line_pixel.
                if (!load_ph_q) begin
                    rd_en     = 1'b1;
                    load_ph_d = 1'b1;
                end else begin
                    line_pixel_d = rd_data_q;
                    load_ph_d    = 1'b0;
                    dly_d        = 3'd1;
                    state_d      = ST_WAIT_ST;
                end
            end
            ST_WAIT_ST: begin
                if (dly_q == DLY_LAST) begin
                    start_d = 1'b1;
                    state_d = ST_SERVE;
                end else begin
                    dly_d = dly_q + 3'd1;
                end
            end
            ST_SERVE: begin
                if (data_update) begin
                    if (rd_row_q == ROW_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        rd_row_d  = rd_row_q + ROW_AW'(1);
                        load_ph_d = 1'b0;
                        state_d   = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_LOAD || state_q == ST_WAIT_ST || state_q == ST_SERVE) begin
            if (sof_v && drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
            // stop overrides everything decided above, including a due start.
            if (stop) begin
                state_d      = ST_IDLE;
                start_d      = 1'b0;
                frame_done_d = 1'b1;
                load_ph_d    = 1'b0;
                line_pixel_d = line_pixel_q;
                rd_row_d     = rd_row_q;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            wr_row_q     <= '0;
            rd_row_q     <= '0;
            pack_q       <= '0;
            load_ph_q    <= 1'b0;
            dly_q        <= '0;
            line_pixel_q <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            wr_row_q     <= wr_row_d;
            rd_row_q     <= rd_row_d;
            pack_q       <= pack_d;
            load_ph_q    <= load_ph_d;
            dly_q        <= dly_d;
            line_pixel_q <= line_pixel_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Row memory: not reset, single write port, registered read port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_row_q] <= pack_shift;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_row_q];
        end
    end

    assign line_pixel = line_pixel_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_bin_frame_line_feeder.sv
// ---------------------------------------------------------------------------
// tb_bin_frame_line_feeder
//
// Randomized and directed stimulus for bin_frame_line_feeder (H_PIX=8,
// V_LINES=4). A frame-level reference model tracks the captured picture,
// the served row and the timing of each row load relative to its trigger
// edge; every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin_frame_line_feeder;

    localparam int unsigned H   = 8;
    localparam int unsigned V   = 4;
    localparam int unsigned AW  = 2;
    localparam int unsigned DLY = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_bit = 1'b0;
    logic         pix_sof = 1'b0;
    logic         data_update = 1'b0;
    logic         stop = 1'b0;
    logic [H-1:0] line_pixel;
    logic         start;
    logic         busy;
    logic         frame_done;
    logic         sof_err;
    logic [7:0]   drop_cnt;

    bin_frame_line_feeder #(
        .H_PIX    (H),
        .V_LINES  (V),
        .ROW_AW   (AW),
        .START_DLY(DLY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_bit    (pix_bit),
        .pix_sof    (pix_sof),
        .line_pixel (line_pixel),
        .start      (start),
        .data_update(data_update),
        .stop       (stop),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CAP, M_SERVE} mmode_t;
    mmode_t       m_mode = M_IDLE;
    logic [H-1:0] m_frame [V];
    int unsigned  m_pc = 0;
    int unsigned  m_row = 0;
    int unsigned  m_trig = 0;
    int unsigned  ecnt = 0;
    logic [H-1:0] e_line = '0;
    logic         e_start = 1'b0;
    logic         e_done = 1'b0;
    logic         e_sof_err = 1'b0;
    logic         e_busy = 1'b0;
    int unsigned  e_drop = 0;

    task automatic put_pixel(input logic b);
        m_frame[m_pc / H][H - 1 - (m_pc % H)] = b;
        m_pc++;
    endtask

    always @(posedge clk) begin : model
        int unsigned k;
        ecnt++;
        e_start   = 1'b0;
        e_done    = 1'b0;
        e_sof_err = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE;
            e_line = '0;
            e_drop = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (pix_valid && pix_sof) begin
                        m_mode = M_CAP;
                        m_pc   = 0;
                        put_pixel(pix_bit);
                    end
                end
                M_CAP: begin
                    if (pix_valid) begin
                        if (pix_sof) begin
                            e_sof_err = 1'b1;
                            m_pc      = 0;
                        end
                        put_pixel(pix_bit);
                        if (m_pc == H * V) begin
                            m_mode = M_SERVE;
                            m_row  = 0;
                            m_trig = ecnt;
                        end
                    end
                end
                default: begin
                    // k = cycles elapsed since the row load was triggered
                    k = ecnt - 1 - m_trig;
                    if (pix_valid && pix_sof && e_drop < 255) e_drop++;
                    if (stop) begin
                        e_done = 1'b1;
                        m_mode = M_IDLE;
                    end else if (k == 1) begin
                        e_line = m_frame[m_row];
                    end else if (k == DLY + 1) begin
                        e_start = 1'b1;
                    end else if (k >= DLY + 2 && data_update) begin
                        if (m_row == V - 1) begin
                            e_done = 1'b1;
                            m_mode = M_IDLE;
                        end else begin
                            m_row++;
                            m_trig = ecnt;
                        end
                    end
                end
            endcase
        end
        e_busy = (m_mode != M_IDLE);
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("start",      64'(start),      64'(e_start));
            chk("frame_done", 64'(frame_done), 64'(e_done));
            chk("sof_err",    64'(sof_err),    64'(e_sof_err));
            chk("busy",       64'(busy),       64'(e_busy));
            chk("drop_cnt",   64'(drop_cnt),   64'(e_drop));
            chk("line_pixel", 64'(line_pixel), 64'(e_line));
        end
    end

    int start_pulses = 0;
    int done_pulses  = 0;
    int sof_pulses   = 0;
    always @(negedge clk) begin
        if (start)      start_pulses++;
        if (frame_done) done_pulses++;
        if (sof_err)    sof_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    logic [H-1:0] stim_rows [V];

    task automatic rand_rows();
        for (int r = 0; r < V; r++) stim_rows[r] = H'($urandom);
    endtask

    task automatic send_pixels(input int npix, input int maxgap, input bit with_sof);
        for (int p = 0; p < npix; p++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_bit   = stim_rows[p / H][H - 1 - (p % H)];
            pix_sof   = with_sof && (p == 0);
            repeat ($urandom_range(maxgap, 0)) begin
                @(negedge clk);
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
                pix_bit   = 1'($urandom);
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_start: no start pulse within 200 cycles at t=%0t", $time);
        end
    endtask

    // mode 0: stop (optionally with data_update) lag cycles after start of stop_row
    // mode 1: data_update on stop_row, then stop lag cycles later
    task automatic serve_frame(input int first_row, input int stop_row, input int mode,
                               input int lag, input int maxdly);
        bit ok;
        for (int r = first_row; r < V; r++) begin
            wait_start(ok);
            if (!ok) return;
            if (r == stop_row && mode == 0) begin
                repeat (lag) @(negedge clk);
                stop        = 1'b1;
                data_update = 1'($urandom);
                @(negedge clk);
                stop        = 1'b0;
                data_update = 1'b0;
                return;
            end
            repeat ($urandom_range(maxdly, 0)) @(negedge clk);
            data_update = 1'b1;
            @(negedge clk);
            data_update = 1'b0;
            if (r == stop_row && mode == 1) begin
                repeat (lag) @(negedge clk);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                return;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [H-1:0] lit [V];
        int unsigned  st_edge;
        int unsigned  du_edge;
        int           s0, d0;
        bit           ok;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frame with hand-computed expectations.
        lit[0] = 8'hA5; lit[1] = 8'h3C; lit[2] = 8'hFF; lit[3] = 8'h01;
        for (int r = 0; r < V; r++) stim_rows[r] = lit[r];
        d0 = done_pulses;
        send_pixels(H * V, 0, 1'b1);
        du_edge = 0;
        for (int r = 0; r < V; r++) begin
            wait_start(ok);
            st_edge = ecnt;
            if (r > 0) chk("start_latency", 64'(st_edge - du_edge), 64'd4);
            chk("row_literal",       64'(line_pixel), 64'(lit[r]));
            chk("model_row_literal", 64'(e_line),     64'(lit[r]));
            repeat (4) @(negedge clk);
            data_update = 1'b1;
            du_edge     = ecnt + 1;
            @(negedge clk);
            data_update = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("done_count_directed", 64'(done_pulses - d0), 64'd1);
        chk("idle_after_frame",    64'(busy),             64'd0);

        // Random frames, random gaps and core response delays.
        for (int f = 0; f < 6; f++) begin
            rand_rows();
            send_pixels(H * V, 2, 1'b1);
            serve_frame(0, -1, 0, 0, 6);
            repeat ($urandom_range(4, 1)) @(negedge clk);
        end

        // Random stops in LOAD / WAIT_ST / SERVE, including stop with data_update.
        for (int f = 0; f < 10; f++) begin
            rand_rows();
            send_pixels(H * V, 1, 1'b1);
            serve_frame(0, int'($urandom_range(V - 1, 0)), int'($urandom_range(1, 0)),
                        int'($urandom_range(4, 0)), 3);
            repeat (5) @(negedge clk);
        end

        // Mid-frame sof: 2.5 rows, then a fresh frame.
        s0 = sof_pulses;
        rand_rows();
        send_pixels(H * 2 + H / 2, 0, 1'b1);
        rand_rows();
        send_pixels(H * V, 1, 1'b1);
        wait_start(ok);
        chk("sof_err_count",   64'(sof_pulses - s0), 64'd1);
        chk("post_sof_row0",   64'(line_pixel),      64'(stim_rows[0]));
        repeat (2) @(negedge clk);
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        serve_frame(1, -1, 0, 0, 3);
        repeat (3) @(negedge clk);

        // stop one cycle after the start of row 2, then a clean frame.
        rand_rows();
        send_pixels(H * V, 0, 1'b1);
        d0 = done_pulses;
        serve_frame(0, 2, 0, 1, 2);
        s0 = start_pulses;
        repeat (20) @(negedge clk);
        chk("stop_done_count", 64'(done_pulses - d0),  64'd1);
        chk("stop_no_start",   64'(start_pulses - s0), 64'd0);
        chk("stop_busy_low",   64'(busy),              64'd0);
        rand_rows();
        send_pixels(H * V, 1, 1'b1);
        serve_frame(0, -1, 0, 0, 4);
        repeat (3) @(negedge clk);

        // 300 sof-marked pixels while the core stalls: drop_cnt saturates.
        rand_rows();
        send_pixels(H * V, 0, 1'b1);
        wait_start(ok);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_sof   = 1'b1;
            pix_bit   = 1'($urandom);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(negedge clk);
        chk("drop_saturated",  64'(drop_cnt),   64'd255);
        chk("drop_row0_kept",  64'(line_pixel), 64'(stim_rows[0]));
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        serve_frame(1, -1, 0, 0, 3);
        repeat (3) @(negedge clk);

        // Reset while in WAIT_ST.
        rand_rows();
        send_pixels(H * V, 0, 1'b1);
        wait_start(ok);
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        s0    = start_pulses;
        rst_n = 1'b0;
        #1;
        chk("rst_start",      64'(start),      64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_line_pixel", 64'(line_pixel), 64'd0);
        chk("rst_drop_cnt",   64'(drop_cnt),   64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_sof_err",    64'(sof_err),    64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rand_rows();
        send_pixels(H * 3, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("reset_no_start",   64'(start_pulses - s0), 64'd0);
        chk("ignore_until_sof", 64'(busy),              64'd0);
        rand_rows();
        send_pixels(H * V, 2, 1'b1);
        serve_frame(0, -1, 0, 0, 5);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
